logic_truth_sweep: RTL and testbench
====================================

// Module: logic_truth_sweep
// PURPOSE
//   Self-sequencing exhaustive tester for a parametrised N-input reduction gate.
//   On start, it drives every input vector 0..2^N_IN-1, holds each for HOLD cycles and evaluates the selected gate.
//   Each result is captured into a truth-table register, and the final table is compared against an expected pattern.
//   It is the on-chip successor to the bench-driven sweep of the 2-input gates, and feeds a status/compare path.
// PARAMETERS
//   N_IN   2   gate input count, legal 1..6
//   HOLD   1   cycles each vector is held, legal >=1
//   TT_W   2**N_IN  localparam, truth-table width (not overridable)
// PORTS
//   clk        in   1        rising-edge clock
//   rst_n      in   1        synchronous reset, active low
//   start      in   1        pulse; begins a sweep when idle
//   abort      in   1        cancels a sweep in progress
//   op         in   3        gate select, sampled at start
//   expect_tt  in   TT_W     expected table, sampled at start
//   busy       out  1        sweep in progress
//   done       out  1        one-cycle completion pulse
//   vec        out  N_IN     current input vector
//   y          out  1        gate result for vec (combinational from vec, op_q)
//   tt         out  TT_W     captured truth table; bit i = f(vector i)
//   pass       out  1        tt == expect_tt; sticky until next start
// BEHAVIOUR
//   Reset (rst_n=0 at edge): state=IDLE; busy=0, done=0, vec=0, tt=0, pass=0; op_q/expect_q=0.
//   op encoding: 0 AND, 1 OR, 2 XOR, 3 XNOR, 4 NAND, 5 NOR, 6 BUF vec[0], 7 NOT vec[0].
//   FSM: IDLE -> RUN -> DONE -> IDLE.
//   IDLE: start=1 -> latch op/expect_tt, vec=0, hold_cnt=0, tt=0, pass=0; go RUN.
//   RUN: busy=1.
//     - hold_cnt counts 0..HOLD-1.
//     - At hold_cnt==HOLD-1: tt[vec]<=y and hold_cnt<=0.
//     - If vec==TT_W-1 -> DONE; else vec<=vec+1.
//     - vec never wraps within a sweep.
//   DONE (one cycle): done=1, busy=0. pass was registered on the edge entering DONE, from the final tt
//     including the last bit. Next state IDLE; vec returns to 0.
//   Latency: start sampled at edge k -> busy from k+1 -> done high in cycle k+1+TT_W*HOLD.
//   start while busy or in DONE: ignored, no effect on the sweep in progress.
//   abort=1 in RUN: next state IDLE, done not pulsed, pass=0, tt keeps its partial value.
//     abort in IDLE/DONE: ignored.
//   start and abort together in IDLE: start wins. In RUN: abort wins.
//   rst_n=0 mid-sweep: full reset values on that edge, no done pulse.
//   tt, pass and op_q hold their values in IDLE until the next accepted start.
// STRUCTURE
//   Package logic_sweep_pkg: op encodings (OP_AND..OP_NOT), FSM state typedef/encoding.
//   Sub-module gate_eval (combinational): ports op, vec -> y; uses reduction operators. One instance.
//   Top: FSM, hold counter ($clog2(HOLD)+1 bits), vec counter, tt capture, compare.
// TESTING
//   1 N_IN=2,HOLD=1, op=3 XNOR, expect=4'b1001 -> vec 0,1,2,3; tt=4'b1001; pass=1; done 5 cycles after start edge.
//   2 N_IN=2, op=0 AND, expect=4'b1001 -> tt=4'b1000, pass=0, done pulses once.
//   3 N_IN=3, op=2 XOR, expect=8'b1001_0110 -> pass=1; HOLD=5 build: each vec held 5 cycles, done at cycle 41.
//   4 abort asserted at vec=2 (N_IN=2) -> busy=0 next cycle, no done, pass=0; a new start then completes normally.
//   5 rst_n=0 at vec=1 -> next cycle all outputs 0, IDLE. start pulsed at vec=2 -> sweep unaffected.
//   6 Each op 0..7 at N_IN=2 against a bench reference model, including BUF=4'b1010 and NOT=4'b0101.

Source files
------------

// File: rtl/logic_sweep_pkg.sv
// Shared encodings for the truth-table sweep: gate select codes and FSM states.
package logic_sweep_pkg;

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_XOR  = 3'd2,
    OP_XNOR = 3'd3,
    OP_NAND = 3'd4,
    OP_NOR  = 3'd5,
    OP_BUF  = 3'd6,
    OP_NOT  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/gate_eval.sv
// Combinational N-input reduction gate selected by a 3-bit op code.
module gate_eval
  import logic_sweep_pkg::*;
#(
  parameter int N_IN = 2
) (
  input  logic [2:0]      op,
  input  logic [N_IN-1:0] vec,
  output logic            y
);

  always_comb begin
    y = 1'b0;
    case (op_e'(op))
      OP_AND:  y = &vec;
      OP_OR:   y = |vec;
      OP_XOR:  y = ^vec;
      OP_XNOR: y = ~^vec;
      OP_NAND: y = ~&vec;
      OP_NOR:  y = ~|vec;
      OP_BUF:  y = vec[0];
      OP_NOT:  y = ~vec[0];
      default: y = 1'b0;
    endcase
  end

endmodule

// File: rtl/logic_truth_sweep.sv
// Self-sequencing exhaustive sweep of gate_eval: walks every input vector,
// captures the truth table and compares it against an expected pattern.
module logic_truth_sweep
  import logic_sweep_pkg::*;
#(
  parameter  int N_IN = 2,
  parameter  int HOLD = 1,
  localparam int TT_W = 2**N_IN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  input  logic [2:0]      op,
  input  logic [TT_W-1:0] expect_tt,
  output logic            busy,
  output logic            done,
  output logic [N_IN-1:0] vec,
  output logic            y,
  output logic [TT_W-1:0] tt,
  output logic            pass
);

  localparam int HC_W = $clog2(HOLD) + 1;
  localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(HOLD - 1);
  localparam logic [N_IN-1:0] VEC_LAST  = '1;

  state_e          r_state;
  logic [HC_W-1:0] r_hold;
  logic [N_IN-1:0] r_vec;
  logic [TT_W-1:0] r_tt;
  logic [TT_W-1:0] r_exp_q;
  logic [2:0]      r_op_q;
  logic            r_busy;
  logic            r_done;
  logic            r_pass;

  logic            w_y;
  logic            w_hold_last;
  logic            w_vec_last;
  logic [TT_W-1:0] w_tt_next;

  gate_eval #(.N_IN(N_IN)) u_gate (
    .op  (r_op_q),
    .vec (r_vec),
    .y   (w_y)
  );

  assign w_hold_last = (r_hold == HOLD_LAST);
  assign w_vec_last  = (r_vec == VEC_LAST);

  // Table including the bit being captured this cycle, so pass sees the final bit.
  always_comb begin
    w_tt_next        = r_tt;
    w_tt_next[r_vec] = w_y;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_hold  <= '0;
      r_vec   <= '0;
      r_tt    <= '0;
      r_exp_q <= '0;
      r_op_q  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_op_q  <= op;
            r_exp_q <= expect_tt;
            r_vec   <= '0;
            r_hold  <= '0;
            r_tt    <= '0;
            r_pass  <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (abort) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_pass  <= 1'b0;
            r_vec   <= '0;
            r_hold  <= '0;
          end else if (w_hold_last) begin
            r_tt   <= w_tt_next;
            r_hold <= '0;
            if (w_vec_last) begin
              r_state <= ST_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_pass  <= (w_tt_next == r_exp_q);
            end else begin
              r_vec <= r_vec + 1'b1;
            end
          end else begin
            r_hold <= r_hold + 1'b1;
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_vec   <= '0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign vec  = r_vec;
  assign y    = w_y;
  assign tt   = r_tt;
  assign pass = r_pass;

endmodule

// File: tb/tb_logic_truth_sweep.sv
// Bench for logic_truth_sweep: a 2-input/HOLD=1 build and a 3-input/HOLD=5 build
// checked against a bit-counting reference of each gate.
module tb_logic_truth_sweep;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       a_start, a_abort;
  logic [2:0] a_op;
  logic [3:0] a_exp, a_tt;
  logic       a_busy, a_done, a_y, a_pass;
  logic [1:0] a_vec;

  logic       b_start, b_abort;
  logic [2:0] b_op;
  logic [7:0] b_exp, b_tt;
  logic       b_busy, b_done, b_y, b_pass;
  logic [2:0] b_vec;

  int n_tests = 0;
  int n_fail  = 0;

  logic_truth_sweep #(.N_IN(2), .HOLD(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .abort(a_abort), .op(a_op),
    .expect_tt(a_exp), .busy(a_busy), .done(a_done), .vec(a_vec), .y(a_y),
    .tt(a_tt), .pass(a_pass)
  );

  logic_truth_sweep #(.N_IN(3), .HOLD(5)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .abort(b_abort), .op(b_op),
    .expect_tt(b_exp), .busy(b_busy), .done(b_done), .vec(b_vec), .y(b_y),
    .tt(b_tt), .pass(b_pass)
  );

  function automatic logic ref_bit(int o, int v, int n);
    int ones = 0;
    for (int b = 0; b < n; b++) ones += (v >> b) & 1;
    case (o)
      0: return ones == n;
      1: return ones > 0;
      2: return (ones % 2) == 1;
      3: return (ones % 2) == 0;
      4: return ones != n;
      5: return ones == 0;
      6: return (v % 2) == 1;
      default: return (v % 2) == 0;
    endcase
  endfunction

  function automatic logic [7:0] ref_tt(int o, int n);
    logic [7:0] t = '0;
    for (int v = 0; v < (1 << n); v++) t[v] = ref_bit(o, v, n);
    return t;
  endfunction

  // Stimulus driver for dut_a: one full sweep, reporting what was observed.
  task automatic sweep_a(input logic [2:0] o, input logic [3:0] e,
                         output int done_at, output int done_cnt,
                         output logic [3:0] tt_o, output logic pass_o,
                         output logic vec_ok);
    @(negedge clk); a_start = 1'b1; a_op = o; a_exp = e;
    @(negedge clk); a_start = 1'b0; a_op = 3'($urandom); a_exp = 4'($urandom);
    done_at = -1; done_cnt = 0; vec_ok = 1'b1; tt_o = 'x; pass_o = 1'bx;
    for (int c = 1; c <= 12; c++) begin
      if (c <= 4 && (a_busy !== 1'b1 || a_vec !== 2'(c - 1))) vec_ok = 1'b0;
      if (a_done === 1'b1) begin
        done_cnt++;
        if (done_at < 0) done_at = c;
        tt_o = a_tt; pass_o = a_pass;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++; if ({a_busy, a_done, a_vec, a_tt, a_pass, a_y} !== '0) begin
      n_fail++; $display("FAIL reset_a: got busy=%b done=%b vec=%0d tt=%b pass=%b y=%b, want all 0",
                         a_busy, a_done, a_vec, a_tt, a_pass, a_y); end
    n_tests++; if ({b_busy, b_done, b_vec, b_tt, b_pass, b_y} !== '0) begin
      n_fail++; $display("FAIL reset_b: got busy=%b done=%b vec=%0d tt=%b pass=%b y=%b, want all 0",
                         b_busy, b_done, b_vec, b_tt, b_pass, b_y); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_xnor_pass;
    int da, dc; logic [3:0] t; logic p, vok;
    sweep_a(3'd3, 4'b1001, da, dc, t, p, vok);
    n_tests++; if (vok !== 1'b1) begin n_fail++; $display("FAIL xnor_vec_seq: got bad vec/busy sequence, want 0,1,2,3 busy"); end
    n_tests++; if (da !== 5) begin n_fail++; $display("FAIL xnor_latency: got done at %0d, want 5", da); end
    n_tests++; if (dc !== 1) begin n_fail++; $display("FAIL xnor_done_cnt: got %0d, want 1", dc); end
    n_tests++; if (t !== 4'b1001) begin n_fail++; $display("FAIL xnor_tt: got %b, want 1001", t); end
    n_tests++; if (p !== 1'b1) begin n_fail++; $display("FAIL xnor_pass: got %b, want 1", p); end
    n_tests++; if ({a_tt, a_pass, a_busy, a_vec} !== {4'b1001, 1'b1, 1'b0, 2'd0}) begin
      n_fail++; $display("FAIL xnor_idle_hold: got tt=%b pass=%b busy=%b vec=%0d, want 1001 1 0 0",
                         a_tt, a_pass, a_busy, a_vec); end
  endtask

  task automatic test_and_fail;
    int da, dc; logic [3:0] t; logic p, vok;
    sweep_a(3'd0, 4'b1001, da, dc, t, p, vok);
    n_tests++; if (t !== 4'b1000) begin n_fail++; $display("FAIL and_tt: got %b, want 1000", t); end
    n_tests++; if (p !== 1'b0) begin n_fail++; $display("FAIL and_pass: got %b, want 0", p); end
    n_tests++; if (dc !== 1) begin n_fail++; $display("FAIL and_done_cnt: got %0d, want 1", dc); end
  endtask

  task automatic test_all_ops;
    int da, dc; logic [3:0] t, r, e; logic p, vok;
    for (int o = 0; o < 8; o++) begin
      r = 4'(ref_tt(o, 2));
      e = ($urandom % 2 == 0) ? r : 4'($urandom);
      sweep_a(3'(o), e, da, dc, t, p, vok);
      n_tests++; if (t !== r || dc !== 1 || da !== 5) begin
        n_fail++; $display("FAIL op%0d_tt: got tt=%b done_cnt=%0d done_at=%0d, want tt=%b 1 5",
                           o, t, dc, da, r); end
      n_tests++; if (p !== (r == e)) begin
        n_fail++; $display("FAIL op%0d_pass: got %b, want %b (exp=%b)", o, p, (r == e), e); end
    end
  endtask

  task automatic test_hold_sweep;
    logic [7:0] r, e;
    int o, done_at, done_cnt; logic vok;
    for (int k = 0; k < 2; k++) begin
      o = (k == 0) ? 2 : int'($urandom % 8);
      e = (k == 0) ? 8'b1001_0110 : 8'($urandom);
      r = ref_tt(o, 3);
      @(negedge clk); b_start = 1'b1; b_op = 3'(o); b_exp = e;
      @(negedge clk); b_start = 1'b0;
      done_at = -1; done_cnt = 0; vok = 1'b1;
      for (int c = 1; c <= 50; c++) begin
        if (c <= 40 && (b_busy !== 1'b1 || b_vec !== 3'((c - 1) / 5))) vok = 1'b0;
        if (b_done === 1'b1) begin done_cnt++; if (done_at < 0) done_at = c; end
        @(negedge clk);
      end
      n_tests++; if (vok !== 1'b1) begin n_fail++; $display("FAIL hold_vec_seq%0d: got bad vec/busy sequence, want each vec 5 cycles", k); end
      n_tests++; if (done_at !== 41 || done_cnt !== 1) begin
        n_fail++; $display("FAIL hold_done%0d: got at %0d count %0d, want 41 1", k, done_at, done_cnt); end
      n_tests++; if (b_tt !== r || b_pass !== (r == e)) begin
        n_fail++; $display("FAIL hold_tt%0d: got tt=%b pass=%b, want tt=%b pass=%b", k, b_tt, b_pass, r, (r == e)); end
    end
  endtask

  task automatic test_abort;
    logic [3:0] r, r2, t_keep; int o, o2, dc; logic seen;
    o = int'($urandom % 8); r = 4'(ref_tt(o, 2));
    @(negedge clk); a_start = 1'b1; a_op = 3'(o); a_exp = r;
    @(negedge clk); a_start = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++; if (a_vec !== 2'd2) begin n_fail++; $display("FAIL abort_at_vec: got vec=%0d, want 2", a_vec); end
    a_abort = 1'b1;
    @(negedge clk); a_abort = 1'b0;
    n_tests++; if ({a_busy, a_done, a_pass} !== 3'b000 || a_tt !== (r & 4'b0011)) begin
      n_fail++; $display("FAIL abort_state: got busy=%b done=%b pass=%b tt=%b, want 0 0 0 %b",
                         a_busy, a_done, a_pass, a_tt, r & 4'b0011); end
    t_keep = a_tt; dc = 0;
    repeat (6) begin @(negedge clk); if (a_done === 1'b1) dc++; end
    a_abort = 1'b1;
    @(negedge clk); a_abort = 1'b0;
    n_tests++; if (dc !== 0 || a_busy !== 1'b0 || a_tt !== t_keep) begin
      n_fail++; $display("FAIL abort_quiet: got done_cnt=%0d busy=%b tt=%b, want 0 0 %b", dc, a_busy, a_tt, t_keep); end
    o2 = (o + 1) % 8; r2 = 4'(ref_tt(o2, 2));
    @(negedge clk); a_start = 1'b1; a_abort = 1'b1; a_op = 3'(o2); a_exp = r2;
    @(negedge clk); a_start = 1'b0; a_abort = 1'b0;
    n_tests++; if (a_busy !== 1'b1) begin n_fail++; $display("FAIL start_beats_abort: got busy=%b, want 1", a_busy); end
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin @(negedge clk); if (a_done === 1'b1) seen = 1'b1; end
    n_tests++; if (!seen || a_tt !== r2 || a_pass !== 1'b1) begin
      n_fail++; $display("FAIL after_abort_sweep: got done=%b tt=%b pass=%b, want 1 %b 1", seen, a_tt, a_pass, r2); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int dc = 0;
    @(negedge clk); a_start = 1'b1; a_op = 3'd1; a_exp = 4'b1110;
    @(negedge clk); a_start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    n_tests++; if ({a_busy, a_done, a_vec, a_tt, a_pass, a_y} !== '0) begin
      n_fail++; $display("FAIL reset_mid: got busy=%b done=%b vec=%0d tt=%b pass=%b y=%b, want all 0",
                         a_busy, a_done, a_vec, a_tt, a_pass, a_y); end
    repeat (6) begin @(negedge clk); if (a_done === 1'b1 || a_busy === 1'b1) dc++; end
    n_tests++; if (dc !== 0) begin n_fail++; $display("FAIL reset_mid_quiet: got %0d active cycles, want 0", dc); end
  endtask

  task automatic test_back_to_back;
    logic [3:0] r; int o, c; logic seen;
    o = int'($urandom % 8); r = 4'(ref_tt(o, 2));
    @(negedge clk); a_start = 1'b1; a_op = 3'(o); a_exp = r;
    @(negedge clk); a_start = 1'b0;
    repeat (2) @(negedge clk);
    a_start = 1'b1; a_op = 3'((o + 3) % 8); a_exp = ~r;
    @(negedge clk); a_start = 1'b0;
    seen = 1'b0; c = 0;
    while (!seen && c < 10) begin
      if (a_done === 1'b1) seen = 1'b1; else begin @(negedge clk); c++; end
    end
    n_tests++; if (!seen || a_tt !== r || a_pass !== 1'b1) begin
      n_fail++; $display("FAIL start_while_busy: got done=%b tt=%b pass=%b, want 1 %b 1", seen, a_tt, a_pass, r); end
    a_start = 1'b1;
    @(negedge clk); a_start = 1'b0;
    n_tests++; if (a_busy !== 1'b0 || a_tt !== r || a_pass !== 1'b1) begin
      n_fail++; $display("FAIL start_in_done: got busy=%b tt=%b pass=%b, want 0 %b 1", a_busy, a_tt, a_pass, r); end
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    a_start = 1'b0; a_abort = 1'b0; a_op = '0; a_exp = '0;
    b_start = 1'b0; b_abort = 1'b0; b_op = '0; b_exp = '0;
    test_reset();
    test_xnor_pass();
    test_and_fail();
    test_all_ops();
    test_hold_sweep();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
